// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece encodings, rotation counts and the 4x4 shape ROM.
// Masks are row-major with bit 15 as the top-left cell.
package tetris_pkg;

    localparam int SHAPE_W    = 16;
    localparam int NUM_SHAPES = 7;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_S = 3'd2,
        PIECE_Z = 3'd3,
        PIECE_J = 3'd4,
        PIECE_T = 3'd5,
        PIECE_L = 3'd6
    } piece_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPAWN  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_CHECK  = 2'd3
    } seq_state_t;

    // Pieces with fewer than four orientations repeat them in the unused slots.
    localparam logic [SHAPE_W-1:0] SHAPE_ROM [NUM_SHAPES][4] = '{
        '{16'h0F00, 16'h2222, 16'h0F00, 16'h2222},
        '{16'h0660, 16'h0660, 16'h0660, 16'h0660},
        '{16'h06C0, 16'h4620, 16'h06C0, 16'h4620},
        '{16'h0C60, 16'h2640, 16'h0C60, 16'h2640},
        '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},
        '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},
        '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440}
    };

    function automatic logic [2:0] rot_count(input logic [2:0] id);
        case (id)
            PIECE_O:                   return 3'd1;
            PIECE_I, PIECE_S, PIECE_Z: return 3'd2;
            default:                   return 3'd4;
        endcase
    endfunction

    function automatic logic [SHAPE_W-1:0] shape_of(input logic [2:0] id, input logic [1:0] r);
        if (id > 3'd6)
            return '0;
        return SHAPE_ROM[id][r];
    endfunction

    // Counts are powers of two, so the modulo reduces to a mask.
    function automatic logic [1:0] step_rot(input logic [1:0] r, input logic [2:0] cnt,
                                            input logic ccw);
        logic [1:0] mask;
        mask = 2'(cnt - 3'd1);
        return ccw ? ((r - 2'd1) & mask) : ((r + 2'd1) & mask);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting toward bit 0.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            q <= SEED;
        else
            q <= {fb, q[15:1]};
    end

endmodule

// File: rtl/piece_rotation_sequencer.sv
// Spawns pieces from a pseudo-random bag and runs rotate requests through an
// external collision check before committing them.
//
// state  | meaning
// IDLE   | no active piece, waiting for the first spawn request
// SPAWN  | promote next_id to the active piece and draw a new preview
// ACTIVE | piece on the board, accepting rotate / spawn requests
// CHECK  | candidate rotation presented, waiting for ok / reject
module piece_rotation_sequencer
    import tetris_pkg::*;
#(
    parameter int          GRID       = 4,
    parameter int          NUM_PIECES = 7,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         CFG_W      = GRID * GRID,
    localparam int         ID_W       = $clog2(NUM_PIECES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             new_piece,
    input  logic             rotate_cw,
    input  logic             rotate_ccw,
    input  logic             cand_ok,
    input  logic             cand_reject,
    output logic [CFG_W-1:0] cur_config,
    output logic [CFG_W-1:0] cand_config,
    output logic             cand_valid,
    output logic [ID_W-1:0]  piece_id,
    output logic [1:0]       rot,
    output logic [ID_W-1:0]  next_id,
    output logic             piece_valid
);

    seq_state_t      state;
    logic [1:0]      cand_rot;
    logic [15:0]     lfsr_q;
    logic [ID_W-1:0] draw_raw;
    logic [ID_W-1:0] draw;
    logic            unused_lfsr;
    logic [2:0]      cnt;
    logic            rot_req;
    logic [1:0]      next_rot;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    // Only the low bits feed the draw; fold once to stay inside the piece range.
    assign draw_raw    = lfsr_q[ID_W-1:0];
    assign draw        = (draw_raw >= ID_W'(NUM_PIECES)) ? draw_raw - ID_W'(NUM_PIECES) : draw_raw;
    assign unused_lfsr = ^lfsr_q[15:ID_W];

    assign cnt      = rot_count(3'(piece_id));
    assign rot_req  = rotate_cw ^ rotate_ccw;
    assign next_rot = step_rot(rot, cnt, rotate_ccw);

    assign cur_config = piece_valid ? CFG_W'(shape_of(3'(piece_id), rot)) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            piece_valid <= 1'b0;
            piece_id    <= '0;
            rot         <= '0;
            next_id     <= '0;
            cand_valid  <= 1'b0;
            cand_config <= '0;
            cand_rot    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_piece)
                        state <= ST_SPAWN;
                end
                ST_SPAWN: begin
                    piece_id    <= next_id;
                    rot         <= '0;
                    piece_valid <= 1'b1;
                    next_id     <= draw;
                    state       <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (new_piece) begin
                        state <= ST_SPAWN;
                    end else if (rot_req && (cnt != 3'd1)) begin
                        cand_rot    <= next_rot;
                        cand_valid  <= 1'b1;
                        cand_config <= CFG_W'(shape_of(3'(piece_id), next_rot));
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // A spawn request wins over any verdict in the same cycle.
                    if (new_piece) begin
                        cand_valid  <= 1'b0;
                        cand_config <= '0;
                        state       <= ST_SPAWN;
                    end else if (cand_ok || cand_reject) begin
                        if (cand_ok && !cand_reject)
                            rot <= cand_rot;
                        cand_valid  <= 1'b0;
                        cand_config <= '0;
                        state       <= ST_ACTIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/piece_rotation_sequencer.md
PIECE_ROTATION_SEQUENCER -- requirements
Module: piece_rotation_sequencer

Interface
REQ-001 SHALL have parameter GRID, default 4, meaning the piece bounding box is GRID x GRID cells and the config width is CFG_W = GRID*GRID.
REQ-002 SHALL have parameter NUM_PIECES, default 7, meaning the number of piece types, encoded I=0, O=1, S=2, Z=3, J=4, T=5, L=6; ID_W = $clog2(NUM_PIECES).
REQ-003 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value; it SHALL be nonzero.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port new_piece, input, 1 bit: single-cycle request to spawn the next piece.
REQ-007 SHALL have ports rotate_cw and rotate_ccw, input, 1 bit each: single-cycle rotation requests.
REQ-008 SHALL have ports cand_ok and cand_reject, input, 1 bit each: collision-checker verdict on the candidate config.
REQ-009 SHALL have port cur_config, output, CFG_W bits: occupancy mask of the active piece, bit 15 = top-left cell, row-major.
REQ-010 SHALL have port cand_config, output, CFG_W bits: proposed rotated mask.
REQ-011 SHALL have port cand_valid, output, 1 bit: cand_config is awaiting a verdict.
REQ-012 SHALL have ports piece_id (ID_W bits), rot (2 bits), next_id (ID_W bits) and piece_valid (1 bit), all outputs.

Function
REQ-013 SHALL implement a state machine with states IDLE, SPAWN, ACTIVE and CHECK.
REQ-014 IDLE: new_piece SHALL move to SPAWN; rotate requests SHALL be ignored.
REQ-015 SPAWN (exactly one cycle) SHALL set piece_id<=next_id, rot<=0, piece_valid<=1 and next_id<=draw, then go to ACTIVE.
REQ-016 The draw SHALL be lfsr[ID_W-1:0], with NUM_PIECES subtracted when the value is >= NUM_PIECES.
REQ-017 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle.
REQ-018 Each piece's rotation count SHALL be: O=1; I, S, Z=2; J, T, L=4.
REQ-019 Candidate rotation SHALL be (rot+1) mod count for cw and (rot-1) mod count for ccw.
REQ-020 cur_config SHALL be combinationally ROM[piece_id][rot] whenever piece_valid=1, else 0.
REQ-021 ACTIVE: exactly one of rotate_cw / rotate_ccw SHALL latch the candidate rotation and go to CHECK; both asserted together SHALL be ignored.
REQ-022 ACTIVE: for the O piece, rotate requests SHALL be ignored.
REQ-023 CHECK SHALL hold cand_valid=1 with cand_config = ROM[piece_id][cand_rot] until a verdict arrives.
REQ-024 CHECK: cand_ok SHALL commit rot<=cand_rot; cand_reject SHALL leave rot unchanged; either SHALL return to ACTIVE with cand_valid=0 on the next cycle.
REQ-025 CHECK: cand_ok and cand_reject asserted together SHALL be treated as reject.
REQ-026 CHECK: rotate requests SHALL be ignored.
REQ-027 new_piece in ACTIVE SHALL go to SPAWN.
REQ-028 new_piece in CHECK SHALL abort the check (cand_valid=0 next cycle, no commit) and go to SPAWN; new_piece SHALL take priority over a same-cycle verdict.
REQ-029 A verdict received outside CHECK SHALL be ignored.

Reset
REQ-030 On resetn=0 the block SHALL immediately enter IDLE with piece_valid=0, piece_id=0, rot=0, next_id=0, cand_valid=0, cand_config=0, cur_config=0 and lfsr=SEED.
REQ-031 Reset SHALL discard any in-flight CHECK with no commit.

Structure
REQ-032 Piece encodings, rotation counts and the CFG_W-bit shape ROM SHALL live in shared package tetris_pkg, reused by board and render logic.
REQ-033 Example ROM entries: I r0=16'h0F00, I r1=16'h2222, O r0=16'h0660.
REQ-034 The LFSR SHALL be a sub-module named lfsr16, with ports clk, resetn and q.

Verification
REQ-035 Reset, then new_piece -> 2 cycles later piece_valid=1, piece_id=0, rot=0, cur_config=16'h0F00.
REQ-036 I piece, rotate_cw, then cand_ok -> cand_config=16'h2222 during CHECK; afterwards rot=1 and cur_config=16'h2222.
REQ-037 I piece at rot=1, rotate_cw, then cand_reject -> rot stays 1 and cur_config stays 16'h2222.
REQ-038 O piece, rotate_ccw -> no CHECK entered and cand_valid stays 0; J piece, 4 accepted cw rotations -> rot sequence 1,2,3,0.
REQ-039 CHECK pending, then new_piece and cand_ok in the same cycle -> no commit, SPAWN follows, rot=0.
REQ-040 resetn pulsed low during CHECK -> all outputs 0 immediately; 10000 spawns -> every piece_id < NUM_PIECES.
